// File: rtl/l1_bus_transform_pkg.sv
// l1_bus_transform_pkg: shared definitions for the L1 line-transfer engine.
//   - Cache FSM state encodings (Idle/WriteBus/ReadBus/WriteCache).
//   - Line/bus geometry: LINE_WIDTH, BUS_WIDTH, BEATS and derived index widths.
//   - line_word(): selects one bus word out of a cache line by beat index.
// Optional feature macro: L1_CRIT_WORD_FIRST_EN (refill starts at the critical word).
package l1_bus_transform_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_WIDTH = 128;
  localparam int unsigned BUS_WIDTH  = 32;
  localparam int unsigned BEATS      = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned BEAT_W     = $clog2(BEATS);
  // Byte-offset bits of a whole line and of one bus word.
  localparam int unsigned OFFSET_W   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned WORD_OFF_W = $clog2(BUS_WIDTH / 8);

  // Cache FSM state as driven by the cache controller.
  typedef enum logic [1:0] {
    CS_IDLE        = 2'b00,
    CS_WRITE_BUS   = 2'b01,
    CS_READ_BUS    = 2'b10,
    CS_WRITE_CACHE = 2'b11
  } cache_state_e;

  // Bus word at beat position idx of a line.
  function automatic logic [BUS_WIDTH-1:0] line_word(
    input logic [LINE_WIDTH-1:0] line,
    input logic [BEAT_W-1:0]     idx
  );
    line_word = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (idx == BEAT_W'(i)) begin
        line_word = line[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  endfunction

endpackage

// File: rtl/l1_line_buffer.sv
// l1_line_buffer: LINE_WIDTH register holding one cache line.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           clear the whole line to zero (highest priority after reset)
//   load          load the full line from load_data
//   load_data     full-line load value
//   wr_en         write one bus word at beat position wr_idx
//   wr_idx        beat index of the word write
//   wr_data       word to write
//   line          current line contents
module l1_line_buffer
  import l1_bus_transform_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [LINE_WIDTH-1:0] load_data,
  input  logic                  wr_en,
  input  logic [BEAT_W-1:0]     wr_idx,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  output logic [LINE_WIDTH-1:0] line
);

  // Line storage with clear, full load and beat-indexed word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (clr) begin
      line <= '0;
    end else if (load) begin
      line <= load_data;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (wr_idx == BEAT_W'(i)) begin
          line[i*BUS_WIDTH +: BUS_WIDTH] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/l1_bus_transform.sv
// l1_bus_transform: line-transfer engine between the L1 cache RAM and the
// 32-bit system bus. Write-back splits a line into BEATS write beats; refill
// assembles BEATS read beats into a line. Completion is a one-cycle done pulse.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   FSM_current_state         cache FSM state (Idle/WriteBus/ReadBus/WriteCache)
//   Cache_Addr                core address of the access causing the transfer
//   RAM_DataWrt               victim line, valid while the cache is in WriteBus
//   Transform_BusWrtDone      one-cycle pulse, write-back complete
//   Transform_BusRdDone       one-cycle pulse, refill complete
//   Transform_BusDataRdBuff   assembled refill line
//   Bus_Req/Bus_Wr/Bus_Addr/Bus_WrData   beat request towards the bus
//   Bus_Ack/Bus_RdData        beat acceptance / read data from the bus
// Optional feature macro: L1_CRIT_WORD_FIRST_EN -- refill begins at the beat
// holding Cache_Addr and wraps; write-back order is unaffected.
module l1_bus_transform
  import l1_bus_transform_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            FSM_current_state,
  input  logic [ADDR_WIDTH-1:0] Cache_Addr,
  input  logic [LINE_WIDTH-1:0] RAM_DataWrt,
  output logic                  Transform_BusWrtDone,
  output logic                  Transform_BusRdDone,
  output logic [LINE_WIDTH-1:0] Transform_BusDataRdBuff,
  output logic                  Bus_Req,
  output logic                  Bus_Wr,
  output logic [ADDR_WIDTH-1:0] Bus_Addr,
  output logic [BUS_WIDTH-1:0]  Bus_WrData,
  input  logic                  Bus_Ack,
  input  logic [BUS_WIDTH-1:0]  Bus_RdData
);

  typedef enum logic [1:0] {
    XS_IDLE = 2'b00,
    XS_WR   = 2'b01,
    XS_RD   = 2'b10,
    XS_DONE = 2'b11
  } xfer_state_e;

  xfer_state_e           state, state_n;
  logic [BEAT_W-1:0]     beat, beat_n;
  logic [BEAT_W-1:0]     ack_cnt, ack_cnt_n;
  logic [ADDR_WIDTH-1:0] line_addr, line_addr_n;

  logic                  line_load;
  logic                  rd_clr;
  logic                  rd_we;
  logic                  req_n;
  logic                  wr_n;
  logic                  wrt_done_n;
  logic                  rd_done_n;

  logic [LINE_WIDTH-1:0] wr_line;
  logic [LINE_WIDTH-1:0] wr_src_c;
  logic [ADDR_WIDTH-1:0] aligned_addr_c;
  logic [BEAT_W-1:0]     start_beat_c;
  logic                  unused_addr_lsbs;

  assign aligned_addr_c   = {Cache_Addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
  assign unused_addr_lsbs = ^Cache_Addr[OFFSET_W-1:0];

  // First refill beat: the critical word when enabled, else beat 0.
`ifdef L1_CRIT_WORD_FIRST_EN
  assign start_beat_c = Cache_Addr[OFFSET_W-1:WORD_OFF_W];
`else
  assign start_beat_c = '0;
`endif

  // The first write beat must come straight from RAM_DataWrt, since the
  // latch is being loaded on the same edge.
  assign wr_src_c = line_load ? RAM_DataWrt : wr_line;

  // Victim line latched at write-back start.
  l1_line_buffer u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load      (line_load),
    .load_data (RAM_DataWrt),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .line      (wr_line)
  );

  // Refill line, assembled word by word at each read ack.
  l1_line_buffer u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (rd_clr),
    .load      (1'b0),
    .load_data ('0),
    .wr_en     (rd_we),
    .wr_idx    (beat),
    .wr_data   (Bus_RdData),
    .line      (Transform_BusDataRdBuff)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    beat_n      = beat;
    ack_cnt_n   = ack_cnt;
    line_addr_n = line_addr;
    line_load   = 1'b0;
    rd_clr      = 1'b0;
    rd_we       = 1'b0;
    req_n       = 1'b0;
    wr_n        = 1'b0;
    wrt_done_n  = 1'b0;
    rd_done_n   = 1'b0;

    unique case (state)
      XS_IDLE: begin
        if (FSM_current_state == CS_WRITE_BUS) begin
          state_n     = XS_WR;
          line_addr_n = aligned_addr_c;
          beat_n      = '0;
          ack_cnt_n   = '0;
          line_load   = 1'b1;
          req_n       = 1'b1;
          wr_n        = 1'b1;
        end else if (FSM_current_state == CS_READ_BUS) begin
          state_n     = XS_RD;
          line_addr_n = aligned_addr_c;
          beat_n      = start_beat_c;
          ack_cnt_n   = '0;
          rd_clr      = 1'b1;
          req_n       = 1'b1;
        end
      end

      XS_WR: begin
        req_n = 1'b1;
        wr_n  = 1'b1;
        if (Bus_Ack) begin
          beat_n    = beat + 1'b1;
          ack_cnt_n = ack_cnt + 1'b1;
          if (ack_cnt == BEAT_W'(BEATS - 1)) begin
            state_n    = XS_DONE;
            req_n      = 1'b0;
            wr_n       = 1'b0;
            wrt_done_n = 1'b1;
          end
        end
      end

      XS_RD: begin
        req_n = 1'b1;
        if (Bus_Ack) begin
          rd_we     = 1'b1;
          beat_n    = beat + 1'b1;
          ack_cnt_n = ack_cnt + 1'b1;
          if (ack_cnt == BEAT_W'(BEATS - 1)) begin
            state_n   = XS_DONE;
            req_n     = 1'b0;
            rd_done_n = 1'b1;
          end
        end
      end

      XS_DONE: begin
        state_n = XS_IDLE;
      end

      default: begin
        state_n = XS_IDLE;
      end
    endcase
  end

  // State and registered bus/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= XS_IDLE;
      beat                 <= '0;
      ack_cnt              <= '0;
      line_addr            <= '0;
      Bus_Req              <= 1'b0;
      Bus_Wr               <= 1'b0;
      Bus_Addr             <= '0;
      Bus_WrData           <= '0;
      Transform_BusWrtDone <= 1'b0;
      Transform_BusRdDone  <= 1'b0;
    end else begin
      state                <= state_n;
      beat                 <= beat_n;
      ack_cnt              <= ack_cnt_n;
      line_addr            <= line_addr_n;
      Bus_Req              <= req_n;
      Bus_Wr               <= wr_n;
      Bus_Addr             <= line_addr_n | ADDR_WIDTH'({beat_n, WORD_OFF_W'(0)});
      Bus_WrData           <= line_word(wr_src_c, beat_n);
      Transform_BusWrtDone <= wrt_done_n;
      Transform_BusRdDone  <= rd_done_n;
    end
  end

endmodule

// File: tb/tb_l1_bus_transform.sv
// tb_l1_bus_transform: directed self-checking bench for l1_bus_transform.
// A per-cycle bus responder (configurable wait states) and a minimal cache
// FSM stand-in are folded into tick(); all stimulus is one linear sequence.
module tb_l1_bus_transform;
  import l1_bus_transform_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   FSM_current_state;
  logic [31:0]  Cache_Addr;
  logic [127:0] RAM_DataWrt;
  logic         Transform_BusWrtDone;
  logic         Transform_BusRdDone;
  logic [127:0] Transform_BusDataRdBuff;
  logic         Bus_Req;
  logic         Bus_Wr;
  logic [31:0]  Bus_Addr;
  logic [31:0]  Bus_WrData;
  logic         Bus_Ack;
  logic [31:0]  Bus_RdData;

  l1_bus_transform dut (
    .clk                     (clk),
    .rst                     (rst),
    .FSM_current_state       (FSM_current_state),
    .Cache_Addr              (Cache_Addr),
    .RAM_DataWrt             (RAM_DataWrt),
    .Transform_BusWrtDone    (Transform_BusWrtDone),
    .Transform_BusRdDone     (Transform_BusRdDone),
    .Transform_BusDataRdBuff (Transform_BusDataRdBuff),
    .Bus_Req                 (Bus_Req),
    .Bus_Wr                  (Bus_Wr),
    .Bus_Addr                (Bus_Addr),
    .Bus_WrData              (Bus_WrData),
    .Bus_Ack                 (Bus_Ack),
    .Bus_RdData              (Bus_RdData)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int wait_cycles = 0;
  int wcnt = 0;
  logic ack_en = 1'b1;
  logic spur = 1'b0;
  logic [1:0] after_wr = 2'b00;
  logic [1:0] after_rd = 2'b00;
  int wrt_cnt = 0;
  int rd_cnt  = 0;
  int wrt_cyc = 0;
  int rd_cyc  = 0;
  logic [31:0] rdmem [4];
  logic [31:0] log_addr [$];
  logic        log_wr   [$];
  logic [31:0] log_data [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs, advance the cache stand-in, drive the bus.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (Transform_BusWrtDone) begin wrt_cnt++; wrt_cyc = cyc; FSM_current_state = after_wr; end
    if (Transform_BusRdDone)  begin rd_cnt++;  rd_cyc  = cyc; FSM_current_state = after_rd; end
    Bus_Ack = 1'b0;
    if (spur && !Bus_Req) begin
      Bus_Ack = 1'b1;
    end else if (Bus_Req && ack_en) begin
      if (wcnt == wait_cycles) begin
        Bus_Ack = 1'b1;
        wcnt = 0;
        log_addr.push_back(Bus_Addr);
        log_wr.push_back(Bus_Wr);
        log_data.push_back(Bus_WrData);
        Bus_RdData = rdmem[Bus_Addr[3:2]];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
    log_data.delete();
    wrt_cnt = 0;
    rd_cnt  = 0;
    wcnt    = 0;
  endtask

  task automatic wait_done(input int wt, input int rt, input int budget);
    int n = 0;
    while ((wrt_cnt < wt || rd_cnt < rt) && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", 128'(wrt_cnt >= wt && rd_cnt >= rt), 128'(1));
  endtask

  int n0;
  int guard;

  initial begin
    rst = 1'b1;
    FSM_current_state = CS_IDLE;
    Cache_Addr = '0;
    RAM_DataWrt = '0;
    Bus_Ack = 1'b0;
    Bus_RdData = '0;
    rdmem[0] = 32'hCAFE_00A0;
    rdmem[1] = 32'hCAFE_00A1;
    rdmem[2] = 32'hCAFE_00A2;
    rdmem[3] = 32'hCAFE_00A3;

    // Reset state
    tick(); tick(); tick();
    chk("rst_req",    128'(Bus_Req), 128'(0));
    chk("rst_wr",     128'(Bus_Wr), 128'(0));
    chk("rst_addr",   128'(Bus_Addr), 128'(0));
    chk("rst_wdata",  128'(Bus_WrData), 128'(0));
    chk("rst_done",   128'({Transform_BusWrtDone, Transform_BusRdDone}), 128'(0));
    chk("rst_buf",    Transform_BusDataRdBuff, 128'(0));
    rst = 1'b0;
    tick();

    // Write-back, zero wait, line 0x1230
    clear_log();
    wait_cycles = 0;
    after_wr = CS_IDLE;
    Cache_Addr = 32'h0000_1234;
    RAM_DataWrt = 128'h44444444_33333333_22222222_11111111;
    FSM_current_state = CS_WRITE_BUS;
    n0 = cyc;
    tick();
    chk("wb_req_n1", 128'(Bus_Req), 128'(1));
    chk("wb_wr_n1",  128'(Bus_Wr), 128'(1));
    wait_done(1, 0, 40);
    tick(); tick(); tick();
    chk("wb_beats",  128'(log_addr.size()), 128'(4));
    chk("wb_a0", 128'(log_addr[0]), 128'(32'h1230));
    chk("wb_a1", 128'(log_addr[1]), 128'(32'h1234));
    chk("wb_a2", 128'(log_addr[2]), 128'(32'h1238));
    chk("wb_a3", 128'(log_addr[3]), 128'(32'h123C));
    chk("wb_d0", 128'(log_data[0]), 128'(32'h11111111));
    chk("wb_d1", 128'(log_data[1]), 128'(32'h22222222));
    chk("wb_d2", 128'(log_data[2]), 128'(32'h33333333));
    chk("wb_d3", 128'(log_data[3]), 128'(32'h44444444));
    chk("wb_wr_flags", 128'({log_wr[0], log_wr[1], log_wr[2], log_wr[3]}), 128'(4'b1111));
    chk("wb_done_cyc", 128'(wrt_cyc - n0), 128'(5));
    chk("wb_done_cnt", 128'(wrt_cnt), 128'(1));
    chk("wb_idle_req", 128'(Bus_Req), 128'(0));

    // Refill, two wait cycles per beat
    clear_log();
    wait_cycles = 2;
    after_rd = CS_IDLE;
    Cache_Addr = 32'h0000_3000;
    FSM_current_state = CS_READ_BUS;
    n0 = cyc;
    wait_done(0, 1, 60);
    tick(); tick(); tick();
    chk("rf_line",     Transform_BusDataRdBuff, {32'hCAFE_00A3, 32'hCAFE_00A2, 32'hCAFE_00A1, 32'hCAFE_00A0});
    chk("rf_done_cyc", 128'(rd_cyc - n0), 128'(13));
    chk("rf_done_cnt", 128'(rd_cnt), 128'(1));
    chk("rf_beats",    128'(log_addr.size()), 128'(4));
    chk("rf_rd_flags", 128'({log_wr[0], log_wr[1], log_wr[2], log_wr[3]}), 128'(4'b0000));

    // WriteBus -> ReadBus chain
    clear_log();
    wait_cycles = 0;
    after_wr = CS_READ_BUS;
    after_rd = CS_IDLE;
    Cache_Addr = 32'h0000_4010;
    RAM_DataWrt = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    FSM_current_state = CS_WRITE_BUS;
    wait_done(1, 1, 80);
    tick(); tick(); tick(); tick(); tick();
    chk("ch_beats", 128'(log_addr.size()), 128'(8));
    chk("ch_flags", 128'({log_wr[0], log_wr[1], log_wr[2], log_wr[3],
                          log_wr[4], log_wr[5], log_wr[6], log_wr[7]}), 128'(8'b1111_0000));
    chk("ch_wd3",   128'(log_data[3]), 128'(32'hDDDD0003));
    chk("ch_ra0",   128'(log_addr[4]), 128'(32'h4010));
    chk("ch_ra3",   128'(log_addr[7]), 128'(32'h401C));
    chk("ch_cnts",  128'({wrt_cnt[7:0], rd_cnt[7:0]}), 128'(16'h0101));
    chk("ch_gap",   128'(rd_cyc - wrt_cyc), 128'(6));
    after_wr = CS_IDLE;

    // Critical-word address, one wait per beat
    clear_log();
    wait_cycles = 1;
    Cache_Addr = 32'h0000_2008;
    FSM_current_state = CS_READ_BUS;
    tick();
    chk("cw_buf_cleared", Transform_BusDataRdBuff, 128'(0));
    wait_done(0, 1, 40);
    tick(); tick();
`ifdef L1_CRIT_WORD_FIRST_EN
    chk("cw_a0", 128'(log_addr[0]), 128'(32'h2008));
    chk("cw_a1", 128'(log_addr[1]), 128'(32'h200C));
    chk("cw_a2", 128'(log_addr[2]), 128'(32'h2000));
    chk("cw_a3", 128'(log_addr[3]), 128'(32'h2004));
`else
    chk("cw_a0", 128'(log_addr[0]), 128'(32'h2000));
    chk("cw_a1", 128'(log_addr[1]), 128'(32'h2004));
    chk("cw_a2", 128'(log_addr[2]), 128'(32'h2008));
    chk("cw_a3", 128'(log_addr[3]), 128'(32'h200C));
`endif
    chk("cw_line", Transform_BusDataRdBuff, {32'hCAFE_00A3, 32'hCAFE_00A2, 32'hCAFE_00A1, 32'hCAFE_00A0});

    // Reset after two acks of a refill
    clear_log();
    wait_cycles = 0;
    Cache_Addr = 32'h0000_5000;
    FSM_current_state = CS_READ_BUS;
    guard = 0;
    while (log_addr.size() < 2 && guard < 20) begin
      tick();
      guard++;
    end
    chk("rs_two_acks", 128'(log_addr.size()), 128'(2));
    ack_en = 1'b0;
    tick();
    rst = 1'b1;
    FSM_current_state = CS_IDLE;
    tick();
    chk("rs_req_drop", 128'(Bus_Req), 128'(0));
    chk("rs_buf_zero", Transform_BusDataRdBuff, 128'(0));
    rst = 1'b0;
    ack_en = 1'b1;
    tick(); tick(); tick();
    chk("rs_no_done", 128'(rd_cnt + wrt_cnt), 128'(0));
    chk("rs_idle_req", 128'(Bus_Req), 128'(0));
    clear_log();
    FSM_current_state = CS_READ_BUS;
    wait_done(0, 1, 40);
    tick(); tick();
    chk("rs_refill_beats", 128'(log_addr.size()), 128'(4));
    chk("rs_refill_line", Transform_BusDataRdBuff, {32'hCAFE_00A3, 32'hCAFE_00A2, 32'hCAFE_00A1, 32'hCAFE_00A0});

    // Spurious ack in IDLE
    clear_log();
    spur = 1'b1;
    tick(); tick(); tick();
    spur = 1'b0;
    tick();
    chk("sp_req",   128'(Bus_Req), 128'(0));
    chk("sp_beats", 128'(log_addr.size()), 128'(0));
    chk("sp_done",  128'(rd_cnt + wrt_cnt), 128'(0));
    chk("sp_buf",   Transform_BusDataRdBuff, {32'hCAFE_00A3, 32'hCAFE_00A2, 32'hCAFE_00A1, 32'hCAFE_00A0});

    // Cache state forced to Idle mid write-back
    clear_log();
    wait_cycles = 1;
    Cache_Addr = 32'h0000_6000;
    RAM_DataWrt = 128'h0000BEE3_0000BEE2_0000BEE1_0000BEE0;
    FSM_current_state = CS_WRITE_BUS;
    tick(); tick();
    FSM_current_state = CS_IDLE;
    wait_done(1, 0, 40);
    tick(); tick();
    chk("fi_beats", 128'(log_addr.size()), 128'(4));
    chk("fi_a3",    128'(log_addr[3]), 128'(32'h600C));
    chk("fi_d3",    128'(log_data[3]), 128'(32'h0000BEE3));
    chk("fi_done",  128'(wrt_cnt), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_bus_transform.md
# l1_bus_transform

Line-transfer engine between the L1 cache RAM and the 32-bit system memory bus. It serves write-back and refill requests signalled by the cache FSM state. A 128-bit write-back line is split into four 32-bit write beats, and four 32-bit read beats are assembled into a 128-bit refill line. Completion is reported to the cache with single-cycle done pulses. It sits between L1I_RAM/L1D_RAM and the bus arbiter.

## Interface
- LINE_WIDTH, 128, cache line width in bits
- BUS_WIDTH, 32, bus data width; BEATS = LINE_WIDTH/BUS_WIDTH (must be a power of two, ≥2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- FSM_current_state  in  2  cache FSM state (Idle 00, WriteBus 01, ReadBus 10, WriteCache 11)
- Cache_Addr  in  32  core address of the access causing the transfer
- RAM_DataWrt  in  LINE_WIDTH  victim line from the cache, valid while the cache is in WriteBus
- Transform_BusWrtDone  out  1  one-cycle pulse: write-back complete
- Transform_BusRdDone  out  1  one-cycle pulse: refill complete
- Transform_BusDataRdBuff  out  LINE_WIDTH  assembled refill line
- Bus_Req  out  1  beat request
- Bus_Wr  out  1  1 = write beat, 0 = read beat
- Bus_Addr  out  32  beat byte address, word aligned
- Bus_WrData  out  BUS_WIDTH  write beat data
- Bus_Ack  in  1  beat accepted (write) / data valid (read)
- Bus_RdData  in  BUS_WIDTH  read beat data, sampled when Bus_Ack is high

## Operation
- States: IDLE, WR (write beats), RD (read beats), DONE.
- IDLE → WR when FSM_current_state == WriteBus.
  - Latch RAM_DataWrt and the line address {Cache_Addr[31:4], 4'b0}.
  - Beat index starts at 0.
- IDLE → RD when FSM_current_state == ReadBus.
  - Latch the line address.
  - Beat index starts at 0, or per the Configuration section.
- Other FSM_current_state values in IDLE: no action.
- WR/RD:
  - Bus_Req = 1.
  - Bus_Addr = line address + beat*4.
  - Bus_Wr = (state == WR).
  - Bus_WrData = latched line[beat*32 +: 32].
  - On Bus_Ack: RD writes Bus_RdData into buffer[beat*32 +: 32]; beat index increments modulo BEATS.
  - After BEATS acks → DONE.
- DONE:
  - Pulse Transform_BusWrtDone (after WR) or Transform_BusRdDone (after RD) for exactly one cycle.
  - Next state is IDLE.
- The cache FSM advances on the done pulse, so IDLE samples the new cache state one cycle later. WriteBus→ReadBus therefore chains directly into a refill with no spurious restart.
- A started transfer always runs to completion, even if FSM_current_state changes mid-transfer. Bus beats are never abandoned.
- Bus_Ack while Bus_Req = 0 is ignored.
- Transform_BusDataRdBuff holds its value from the RD done pulse until the next RD start. It is cleared to 0 when a new RD begins.
- Reset values:
  - state IDLE, beat 0
  - Bus_Req 0, Bus_Wr 0, Bus_Addr 0, Bus_WrData 0
  - both done pulses 0
  - Transform_BusDataRdBuff 0
- Reset asserted mid-transfer: return to IDLE next cycle, Bus_Req drops, no done pulse is issued.

## Timing
- All outputs are registered.
- Start: cache state sampled in IDLE at cycle N; Bus_Req is high from cycle N+1.
- Bus_Req, Bus_Addr, Bus_Wr and Bus_WrData are held stable until Bus_Ack. The next beat is presented in the cycle after the ack, with no idle gap.
- Zero-wait bus (Bus_Ack in the same cycle as Bus_Req): beats in cycles N+1..N+4, done pulse at N+5, IDLE at N+6. Minimum transfer is BEATS+2 cycles.
- Each wait cycle (Bus_Req=1, Bus_Ack=0) delays all later events by one cycle.

## Configuration
- L1_CRIT_WORD_FIRST_EN defined: RD starts at beat Cache_Addr[3:2] and wraps modulo BEATS (e.g. 2,3,0,1). Each word is still placed at its line position.
- L1_CRIT_WORD_FIRST_EN undefined: RD always issues beats 0..BEATS-1.
- WR is always 0..BEATS-1 in both builds.

## Structure
- Define.v (shared): cache FSM encodings Idle/WriteBus/ReadBus/WriteCache, LINE_WIDTH/BUS_WIDTH defaults, macro L1_CRIT_WORD_FIRST_EN.
- Transform-local: the four internal state encodings.
- One natural sub-module: l1_line_buffer, a LINE_WIDTH register with a beat-indexed write port, a clear, and a full-line output. Used for both the write-latch and the refill buffer.

## Test plan
- Write-back, zero-wait, line 0x0000_1230, RAM_DataWrt = 0x44444444_33333333_22222222_11111111:
  - required: write beats to 0x1230/1234/1238/123C with data 11111111, 22222222, 33333333, 44444444
  - required: Transform_BusWrtDone high exactly at cycle N+5
- Refill, 2 wait cycles per beat, read data A0..A3:
  - required: Transform_BusDataRdBuff = {A3,A2,A1,A0}
  - required: Transform_BusRdDone is a one-cycle pulse 13 cycles after start
- WriteBus→ReadBus chain:
  - required: exactly 4 write beats then 4 read beats, one WrtDone and one RdDone, no third transfer
- Cache_Addr = 0x0000_2008 with L1_CRIT_WORD_FIRST_EN:
  - required: read order 0x2008, 0x200C, 0x2000, 0x2004 and a correctly placed line
  - without the macro: order 0x2000..0x200C
- rst asserted after 2 acks of a refill:
  - required: Bus_Req = 0 the next cycle, no done pulse, buffer = 0
  - required: a subsequent ReadBus runs a full 4-beat refill
- Spurious Bus_Ack in IDLE and FSM_current_state forced to Idle mid-transfer:
  - required: no state change in IDLE
  - required: the started transfer completes with its done pulse
